// File: rtl/div_if.sv
// Execute-stage <-> divider handshake: operands and start/annul in, HI/LO result and ready out.
interface div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   // Execute stage drives the request and consumes the result.
   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   // Divider accepts the request and returns the result.
   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, with the signs of quotient and remainder fixed up at the end.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FREE   | idle, waiting for start_i with annul_i low
//   BYZERO | divisor was zero, force a zero result
//   ON     | 32 shift/subtract iterations, then sign fixups
//   END    | result valid, held until start_i drops
module div (
   input  logic   clk,
   input  logic   rst,
   div_if.slave   bus
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   logic        sign1_q;
   logic        sign2_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [63:0] result_q;
   logic        ready_q;

   logic        sign1_d;
   logic        sign2_d;
   logic [31:0] abs1_d;
   logic [31:0] abs2_d;
   logic [32:0] shift_d;
   logic [32:0] trial_d;
   logic [31:0] rem_d;
   logic [31:0] quo_d;

   // Operand magnitudes and one restoring step. The shifted remainder needs
   // 33 bits since it can reach 2*(divisor-1)+1 before the subtraction.
   always_comb begin
      sign1_d = bus.signed_div_i & bus.opdata1_i[31];
      sign2_d = bus.signed_div_i & bus.opdata2_i[31];
      abs1_d  = sign1_d ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
      abs2_d  = sign2_d ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
      shift_d = {rem_q, quo_q[31]};
      trial_d = shift_d - {1'b0, dvs_q};
      if (!trial_d[32]) begin
         rem_d = trial_d[31:0];
         quo_d = {quo_q[30:0], 1'b1};
      end else begin
         rem_d = shift_d[31:0];
         quo_d = {quo_q[30:0], 1'b0};
      end
   end

   // Sequencing FSM with registered result/ready.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= FREE;
         cnt_q    <= 6'd0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         dvs_q    <= 32'd0;
         result_q <= 64'd0;
         ready_q  <= 1'b0;
      end else begin
         case (state_q)
            FREE: begin
               ready_q  <= 1'b0;
               result_q <= 64'd0;
               if (bus.start_i && !bus.annul_i) begin
                  sign1_q <= sign1_d;
                  sign2_q <= sign2_d;
                  if (bus.opdata2_i == 32'd0) begin
                     state_q <= BYZERO;
                  end else begin
                     quo_q   <= abs1_d;
                     dvs_q   <= abs2_d;
                     rem_q   <= 32'd0;
                     cnt_q   <= 6'd0;
                     state_q <= ON;
                  end
               end
            end
            BYZERO: begin
               rem_q   <= 32'd0;
               quo_q   <= 32'd0;
               state_q <= END;
            end
            ON: begin
               if (bus.annul_i) begin
                  cnt_q    <= 6'd0;
                  ready_q  <= 1'b0;
                  result_q <= 64'd0;
                  state_q  <= FREE;
               end else if (cnt_q != 6'd32) begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + 6'd1;
               end else begin
                  if (sign1_q ^ sign2_q) quo_q <= ~quo_q + 32'd1;
                  if (sign1_q)           rem_q <= ~rem_q + 32'd1;
                  cnt_q   <= 6'd0;
                  state_q <= END;
               end
            end
            END: begin
               if (bus.start_i) begin
                  ready_q  <= 1'b1;
                  result_q <= {rem_q, quo_q};
               end else begin
                  ready_q  <= 1'b0;
                  result_q <= 64'd0;
                  state_q  <= FREE;
               end
            end
            default: state_q <= FREE;
         endcase
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: latency, signed/unsigned results,
// divide-by-zero, annul, mid-operation reset, result hold.
module tb_div;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   div_if bus ();

   div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Start a divide, measure latency to ready, check result, hold start for
   // 'hold' extra cycles, then drop start and check the outputs clear.
   // If 'scramble' is set the operands are changed a few cycles into ON.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res,
                          input int exp_lat, input int hold, input bit scramble);
      int n;
      bit got;
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      bus.annul_i      = 1'b0;
      n   = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.ready_o) got = 1'b1;
         if (scramble && n == 5) begin
            bus.opdata1_i    = ~a;
            bus.opdata2_i    = 32'h3;
            bus.signed_div_i = ~sgn;
         end
      end
      chk({tag, " latency"}, 64'(n - 1), 64'(exp_lat));
      chk({tag, " result"}, bus.result_o, exp_res);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
         chk({tag, " hold result"}, bus.result_o, exp_res);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      chk({tag, " drop ready"}, 64'(bus.ready_o), 64'd0);
      chk({tag, " drop result"}, bus.result_o, 64'd0);
   endtask

   initial begin
      int seen;
      n_cmp = 0;
      n_err = 0;
      rst              = 1'b0;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd0;
      bus.opdata2_i    = 32'd0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ready", 64'(bus.ready_o), 64'd0);
      chk("reset result", bus.result_o, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run_div("udiv 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 0, 1'b0);
      run_div("sdiv -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b0);
      run_div("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 0, 1'b0);
      run_div("udiv big", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34, 0, 1'b0);
      run_div("udiv by0", 1'b0, 32'd12345, 32'd0, 64'd0, 2, 0, 1'b0);
      run_div("sdiv by0", 1'b1, 32'd12345, 32'd0, 64'd0, 2, 0, 1'b0);

      // Annul during ON: flush drops start together with annul.
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      repeat (10) @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      bus.annul_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready_o) seen++;
      end
      chk("annul no ready", 64'(seen), 64'd0);
      run_div("udiv 9/4 after annul", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 34, 0, 1'b0);

      // Reset in the middle of a divide.
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      repeat (20) @(negedge clk);
      rst         = 1'b0;
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("midreset ready", 64'(bus.ready_o), 64'd0);
      chk("midreset result", bus.result_o, 64'd0);
      rst = 1'b1;
      run_div("sdiv overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 0, 1'b0);

      // Hold start after ready, and scramble operands during ON.
      run_div("hold 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 5, 1'b0);
      run_div("scramble -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
